// File: rtl/clz_pipe_pkg.sv
// Shared sizing helpers for the pipelined leading-zero counter and the log2 datapath top.
package clz_pipe_pkg;

  function automatic int clz_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ranks(input int nstg, input int reg_every);
    return (nstg + reg_every - 1) / reg_every;
  endfunction

  function automatic int res_w(input int width);
    return clz_log2(width) + 1;
  endfunction

  // Width of the running word entering stage j; halves per stage when narrowed.
  function automatic int bus_w(input int width, input int j, input bit narrow);
    return narrow ? (width >> j) : width;
  endfunction

  function automatic int bus_off(input int width, input int j, input bit narrow);
    int off;
    off = 0;
    for (int i = 0; i < j; i++) off += bus_w(width, i, narrow);
    return off;
  endfunction

endpackage

// File: rtl/clz_pipe_stage.sv
// One combinational leading-zero halving step. With CLZ_PIPE_NORM_EN the word is
// shifted at full width; otherwise only the half still under test is kept.
module clz_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 16,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [CNT_W-1:0] i_count,
`ifdef CLZ_PIPE_NORM_EN
  output logic [WIDTH-1:0] o_word,
`else
  output logic [SHIFT-1:0] o_word,
`endif
  output logic [CNT_W-1:0] o_count
);

  logic top_zero;

  always_comb begin
    top_zero = (i_word[WIDTH-1 -: SHIFT] == '0);
`ifdef CLZ_PIPE_NORM_EN
    o_word   = top_zero ? (i_word << SHIFT) : i_word;
`else
    o_word   = top_zero ? i_word[SHIFT-1:0] : i_word[WIDTH-1 -: SHIFT];
`endif
    o_count  = top_zero ? (i_count | CNT_W'(SHIFT)) : i_count;
  end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined count-leading-zeros with a global-advance valid/ready pipe.
// Define CLZ_PIPE_NORM_EN to also emit the MSB-aligned word on o_norm.
module clz_pipe
  import clz_pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [WIDTH-1:0]         i_word,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [res_w(WIDTH)-1:0]  o_result,
`ifdef CLZ_PIPE_NORM_EN
  output logic                     o_zero,
  output logic [WIDTH-1:0]         o_norm
`else
  output logic                     o_zero
`endif
);

  localparam int NSTG  = clz_log2(WIDTH);
  localparam int RES_W = res_w(WIDTH);
`ifdef CLZ_PIPE_NORM_EN
  localparam bit NARROW = 1'b0;
`else
  localparam bit NARROW = 1'b1;
`endif
  localparam int BUS_TOT = bus_off(WIDTH, NSTG + 1, NARROW);
  localparam int FIN_OFF = bus_off(WIDTH, NSTG, NARROW);
  localparam int FIN_W   = bus_w(WIDTH, NSTG, NARROW);

  // Boundary j of the chain occupies bus_word[bus_off(j) +: bus_w(j)].
  logic [BUS_TOT-1:0] bus_word;
  logic [RES_W-1:0]   bus_cnt [NSTG+1];
  logic               bus_vld [NSTG+1];
  logic               adv;
  logic               fin_zero;

  assign adv         = ~o_valid | o_ready;
  assign i_ready     = adv;
  assign bus_word[WIDTH-1:0] = i_word;
  assign bus_cnt[0]  = '0;
  assign bus_vld[0]  = i_valid;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int IW = bus_w(WIDTH, k, NARROW);
    localparam int OW = bus_w(WIDTH, k + 1, NARROW);
    localparam int IO = bus_off(WIDTH, k, NARROW);
    localparam int OO = bus_off(WIDTH, k + 1, NARROW);

    logic [OW-1:0]    st_word;
    logic [RES_W-1:0] st_cnt;

    clz_pipe_stage #(
      .WIDTH (IW),
      .SHIFT (WIDTH >> (k + 1)),
      .CNT_W (RES_W)
    ) u_stage (
      .i_word  (bus_word[IO +: IW]),
      .i_count (bus_cnt[k]),
      .o_word  (st_word),
      .o_count (st_cnt)
    );

    if (((k + 1) % REG_EVERY == 0) || (k == NSTG - 1)) begin : g_rank
      // Rank boundary: every rank moves together on adv, bubbles included.
      logic [OW-1:0]    word_q, word_d;
      logic [RES_W-1:0] cnt_q, cnt_d;
      logic             vld_q, vld_d;

      always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (adv) begin
          word_d = st_word;
          cnt_d  = st_cnt;
          vld_d  = bus_vld[k];
        end
      end

      always_ff @(posedge clk) begin
        word_q <= word_d;
        cnt_q  <= cnt_d;
        if (reset) vld_q <= 1'b0;
        else       vld_q <= vld_d;
      end

      assign bus_word[OO +: OW] = word_q;
      assign bus_cnt[k+1]       = cnt_q;
      assign bus_vld[k+1]       = vld_q;
    end else begin : g_comb
      assign bus_word[OO +: OW] = st_word;
      assign bus_cnt[k+1]       = st_cnt;
      assign bus_vld[k+1]       = bus_vld[k];
    end
  end

  // A zero MSB after the final stage only happens for an all-zero input.
  assign fin_zero = ~bus_word[FIN_OFF + FIN_W - 1];
  assign o_valid  = bus_vld[NSTG];
  assign o_zero   = o_valid & fin_zero;
  assign o_result = !o_valid ? '0 : (fin_zero ? RES_W'(WIDTH) : bus_cnt[NSTG]);
`ifdef CLZ_PIPE_NORM_EN
  assign o_norm   = o_valid ? bus_word[FIN_OFF +: WIDTH] : '0;
`endif

endmodule

// File: tb/tb_clz_pipe.sv
// Directed bench for clz_pipe: WIDTH=32 main instance plus a WIDTH/REG_EVERY sweep.
// o_norm checks are compiled in only when CLZ_PIPE_NORM_EN is defined.
module tb_clz_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, o_valid, o_ready, o_zero;
  logic [31:0] i_word;
  logic [5:0]  o_result;
`ifdef CLZ_PIPE_NORM_EN
  logic [31:0] o_norm;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clz_pipe #(.WIDTH(32), .REG_EVERY(2)) dut (
    .clk      (clk),
    .reset    (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_word   (i_word),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_result (o_result),
`ifdef CLZ_PIPE_NORM_EN
    .o_zero   (o_zero),
    .o_norm   (o_norm)
`else
    .o_zero   (o_zero)
`endif
  );

  // Sweep instances: index g -> WIDTH {8,8,16,16,64,64}, REG_EVERY {1,NSTG,...}.
  logic [63:0] sw_word   [6];
  logic        sw_ivalid [6];
  logic        sw_iready [6];
  logic        sw_ovalid [6];
  logic        sw_zero   [6];
  logic [6:0]  sw_res    [6];
`ifdef CLZ_PIPE_NORM_EN
  logic [63:0] sw_norm   [6];
`endif

  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int W  = (g < 2) ? 8 : ((g < 4) ? 16 : 64);
    localparam int NS = (g < 2) ? 3 : ((g < 4) ? 4 : 6);
    localparam int RE = (g % 2 == 0) ? 1 : NS;
    logic [NS:0] res;
`ifdef CLZ_PIPE_NORM_EN
    logic [W-1:0] nrm;
    assign sw_norm[g] = 64'(nrm);
`endif
    assign sw_res[g] = 7'(res);
    clz_pipe #(.WIDTH(W), .REG_EVERY(RE)) u_sw (
      .clk      (clk),
      .reset    (rst),
      .i_valid  (sw_ivalid[g]),
      .i_ready  (sw_iready[g]),
      .i_word   (sw_word[g][W-1:0]),
      .o_valid  (sw_ovalid[g]),
      .o_ready  (1'b1),
      .o_result (res),
`ifdef CLZ_PIPE_NORM_EN
      .o_zero   (sw_zero[g]),
      .o_norm   (nrm)
`else
      .o_zero   (sw_zero[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_clz(input logic [63:0] w, input int width);
    for (int i = width - 1; i >= 0; i--) begin
      if (w[i]) return width - 1 - i;
    end
    return width;
  endfunction

  function automatic logic [63:0] mask_w(input int width);
    return (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] w, input string tag,
                          input int exp_res, input logic [31:0] exp_norm);
    int lat;
    i_word  = w;
    i_valid = 1'b1;
    #1;
    check({tag, "_iready"}, i_ready, 1);
    tick;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      tick;
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_res"}, o_result, exp_res);
    check({tag, "_zero"}, o_zero, (exp_res == 32));
`ifdef CLZ_PIPE_NORM_EN
    check({tag, "_norm"}, o_norm, exp_norm);
`else
    if (exp_norm == 32'hdead_beef) $display("note: unexpected norm sentinel");
`endif
    tick;
  endtask

  logic [31:0] s_words [8] = '{32'h0000_0001, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000,
                               32'h0000_0F00, 32'h4000_0000, 32'h0000_0002, 32'h0080_0000};
  int          s_exp   [8] = '{31, 0, 15, 32, 20, 1, 30, 8};
  int          rk      [6] = '{3, 1, 4, 1, 6, 1};
  int          ws      [6] = '{8, 8, 16, 16, 64, 64};
  logic [63:0] dword   [6] = '{64'h10, 64'h10, 64'h0100, 64'h0100,
                               64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
  int          dexp    [6] = '{3, 3, 7, 7, 32, 32};

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int idx, rcv, lat, e;
    bit in_x;
    logic [63:0] w;
    logic [63:0] wq[$];

    // Reset with i_valid held high: nothing may be captured.
    rst = 1'b1; i_valid = 1'b1; i_word = 32'h1; o_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin sw_word[g] = '0; sw_ivalid[g] = 1'b0; end
    tick; tick;
    check("rst_ovalid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_zero", o_zero, 0);
`ifdef CLZ_PIPE_NORM_EN
    check("rst_norm", o_norm, 0);
`endif
    rst = 1'b0; i_valid = 1'b0;
    #1;
    check("rst_iready", i_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check("rst_ignored", o_valid, 0);
      tick;
    end

    send_one(32'h0001_0000, "v15",  15, 32'h8000_0000);
    send_one(32'h8000_0000, "v0",   0,  32'h8000_0000);
    send_one(32'h0000_0001, "v31",  31, 32'h8000_0000);
    send_one(32'h0000_0000, "vzero", 32, 32'h0000_0000);
    send_one(32'h0040_0000, "v9",   9,  32'h8000_0000);
    send_one(32'h0000_5A00, "v17",  17, 32'hB400_0000);

    // Back-to-back stream with a 4-cycle downstream stall.
    idx = 0; rcv = 0;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      o_ready = !(c >= 5 && c < 9);
      i_valid = (idx < 8);
      i_word  = (idx < 8) ? s_words[idx] : 32'h0;
      #1;
      in_x = i_valid && i_ready;
      if (o_valid && !o_ready) begin
        check("stall_iready", i_ready, 0);
        check("stall_hold", o_result, s_exp[rcv]);
      end
      if (o_valid && o_ready) begin
        check("stream_res", o_result, s_exp[rcv]);
        check("stream_zero", o_zero, (s_exp[rcv] == 32));
        rcv++;
      end
      tick;
      if (in_x) idx++;
    end
    i_valid = 1'b0; o_ready = 1'b1;
    check("stream_count", rcv, 8);
    for (int c = 0; c < 4; c++) begin
      check("stream_dup", o_valid, 0);
      tick;
    end

    // Reset while three words are in flight.
    i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_word = s_words[c];
      tick;
    end
    rst = 1'b1; i_valid = 1'b0;
    tick;
    check("flush_ovalid", o_valid, 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("flush_quiet", o_valid, 0);
      tick;
    end
    send_one(32'h0000_0100, "post_rst", 23, 32'h8000_0000);

    // Width / REG_EVERY sweep: latency, directed value, then random stream.
    for (int g = 0; g < 6; g++) begin
      sw_word[g] = dword[g];
      sw_ivalid[g] = 1'b1;
      #1;
      check("sw_iready", sw_iready[g], 1);
      tick;
      sw_ivalid[g] = 1'b0;
      lat = 1;
      while (!sw_ovalid[g] && lat < 20) begin
        tick;
        lat++;
      end
      check($sformatf("sw%0d_lat", g), lat, rk[g]);
      check($sformatf("sw%0d_res", g), sw_res[g], dexp[g]);
      tick;

      wq.delete();
      for (int c = 0; c < 40; c++) begin
        if (c < 12) begin
          w = ({$urandom, $urandom} >> $urandom_range(0, ws[g])) & mask_w(ws[g]);
          sw_word[g] = w;
          sw_ivalid[g] = 1'b1;
          wq.push_back(w);
        end else begin
          sw_ivalid[g] = 1'b0;
        end
        tick;
        if (sw_ovalid[g]) begin
          if (wq.size() == 0) begin
            check($sformatf("sw%0d_extra", g), sw_ovalid[g], 0);
          end else begin
            w = wq.pop_front();
            e = ref_clz(w, ws[g]);
            check($sformatf("sw%0d_rnd_res", g), sw_res[g], e);
            check($sformatf("sw%0d_rnd_zero", g), sw_zero[g], (e == ws[g]));
`ifdef CLZ_PIPE_NORM_EN
            check($sformatf("sw%0d_rnd_norm", g), sw_norm[g], (w << e) & mask_w(ws[g]));
`endif
          end
        end
        if (c >= 12 && wq.size() == 0) break;
      end
      check($sformatf("sw%0d_left", g), wq.size(), 0);
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
